// File: rtl/clock_pkg.sv
// Shared time-of-day types and limits for the clock design.
// Used by the setup stage, the time counter and the display decoder.
package clock_pkg;

    typedef struct packed {
        logic [7:0] hours;
        logic [7:0] minutes;
        logic [7:0] seconds;
    } hms_t;

    localparam logic [7:0] MAX_SEC  = 8'd59;
    localparam logic [7:0] MAX_MIN  = 8'd59;
    localparam logic [7:0] MAX_HOUR = 8'd23;

    // Each field is checked on its own; an out-of-range field becomes zero.
    function automatic hms_t range_check(input hms_t t);
        hms_t r;
        r.hours   = (t.hours   > MAX_HOUR) ? 8'd0 : t.hours;
        r.minutes = (t.minutes > MAX_MIN)  ? 8'd0 : t.minutes;
        r.seconds = (t.seconds > MAX_SEC)  ? 8'd0 : t.seconds;
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler that divides the system clock down to one tick per CLK_HZ cycles.
// The count freezes while run is low and restarts from zero on clear.
module tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         wrap;

    assign wrap = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    // Tick marks the edge on which the count wraps back to zero.
    assign tick = run & ~clear & wrap;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/time_counter.sv
// Time-of-day counter: hh:mm:ss advanced once per second, loadable from setup.
// A load edge restarts the second and always beats a coincident advance.
module time_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [23:0] setup_data,
    input  logic        setup_imp,
    output logic [23:0] data_ch,
    output logic        sec_tick,
    output logic        day_tick
);

    logic setup_imp_q;
    logic load;
    logic tick;

    hms_t time_q;
    hms_t time_d;
    logic sec_tick_q;
    logic sec_tick_d;
    logic day_tick_q;
    logic day_tick_d;

    assign load = setup_imp & ~setup_imp_q;

    tick_gen #(
        .CLK_HZ(CLK_HZ)
    ) u_tick_gen (
        .clock(clock),
        .reset(reset),
        .run  (run),
        .clear(load),
        .tick (tick)
    );

    always_comb begin
        time_d     = time_q;
        sec_tick_d = 1'b0;
        day_tick_d = 1'b0;
        if (load) begin
            time_d = range_check(hms_t'(setup_data));
        end else if (tick) begin
            sec_tick_d = 1'b1;
            // Cascade the carries so the whole rollover lands in one cycle.
            if (time_q.seconds == MAX_SEC) begin
                time_d.seconds = 8'd0;
                if (time_q.minutes == MAX_MIN) begin
                    time_d.minutes = 8'd0;
                    if (time_q.hours == MAX_HOUR) begin
                        time_d.hours = 8'd0;
                        day_tick_d   = 1'b1;
                    end else begin
                        time_d.hours = time_q.hours + 8'd1;
                    end
                end else begin
                    time_d.minutes = time_q.minutes + 8'd1;
                end
            end else begin
                time_d.seconds = time_q.seconds + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            setup_imp_q <= 1'b0;
            time_q      <= '0;
            sec_tick_q  <= 1'b0;
            day_tick_q  <= 1'b0;
        end else begin
            setup_imp_q <= setup_imp;
            time_q      <= time_d;
            sec_tick_q  <= sec_tick_d;
            day_tick_q  <= day_tick_d;
        end
    end

    assign data_ch  = time_q;
    assign sec_tick = sec_tick_q;
    assign day_tick = day_tick_q;

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter with CLK_HZ=4 against a seconds-of-day model.
// Directed scenarios followed by a randomized run/load/data sequence.
module tb_time_counter;

    localparam int CLK_HZ = 4;
    localparam int DAY    = 86400;

    logic        clock;
    logic        reset;
    logic        run;
    logic [23:0] setup_data;
    logic        setup_imp;
    logic [23:0] data_ch;
    logic        sec_tick;
    logic        day_tick;

    int compared;
    int mismatched;

    // Reference model: time as seconds since midnight plus cycles into the second.
    int m_t;
    int m_phase;
    bit m_prev;
    bit m_sec;
    bit m_day;

    time_counter #(
        .CLK_HZ(CLK_HZ)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .setup_data(setup_data),
        .setup_imp (setup_imp),
        .data_ch   (data_ch),
        .sec_tick  (sec_tick),
        .day_tick  (day_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [23:0] hms_of(input int t);
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        h = 8'(t / 3600);
        m = 8'((t / 60) % 60);
        s = 8'(t % 60);
        return {h, m, s};
    endfunction

    function automatic int clip(input int v, input int max_v);
        return (v > max_v) ? 0 : v;
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t     = 0;
        m_phase = 0;
        m_prev  = 1'b0;
        m_sec   = 1'b0;
        m_day   = 1'b0;
    endtask

    // One clock edge: update the model from the sampled inputs, then compare.
    task automatic step();
        bit load;
        int h;
        int m;
        int s;
        @(posedge clock);
        load  = setup_imp && !m_prev;
        m_sec = 1'b0;
        m_day = 1'b0;
        if (load) begin
            h       = clip(int'(setup_data[23:16]), 23);
            m       = clip(int'(setup_data[15:8]), 59);
            s       = clip(int'(setup_data[7:0]), 59);
            m_t     = h * 3600 + m * 60 + s;
            m_phase = 0;
        end else if (run) begin
            m_phase++;
            if (m_phase == CLK_HZ) begin
                m_phase = 0;
                m_t     = (m_t + 1) % DAY;
                m_sec   = 1'b1;
                m_day   = (m_t == 0);
            end
        end
        m_prev = setup_imp;
        #1;
        $display("t=%0t run=%0b imp=%0b in=%h data_ch=%h sec=%0b day=%0b ref=%h",
                 $time, run, setup_imp, setup_data, data_ch, sec_tick, day_tick, hms_of(m_t));
        check("data_ch", data_ch, hms_of(m_t));
        check("sec_tick", {23'd0, sec_tick}, {23'd0, m_sec});
        check("day_tick", {23'd0, day_tick}, {23'd0, m_day});
    endtask

    task automatic pulse_load(input logic [23:0] value);
        setup_data = value;
        setup_imp  = 1'b1;
        step();
        setup_imp  = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        run        = 1'b1;
        setup_imp  = 1'b0;
        setup_data = 24'h0;
        model_reset();

        // Reset state
        @(posedge clock);
        @(posedge clock);
        #1;
        check("reset_data", data_ch, 24'h000000);
        check("reset_sec", {23'd0, sec_tick}, 24'd0);
        check("reset_day", {23'd0, day_tick}, 24'd0);
        @(negedge clock);
        reset = 1'b0;

        // Free run: first advance on the 4th edge
        for (int i = 0; i < 4; i++) step();
        check("first_second", data_ch, 24'h000001);
        check("first_tick", {23'd0, sec_tick}, 24'd1);
        for (int i = 0; i < 6; i++) step();

        // Asynchronous reset mid-count clears at once
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_data", data_ch, 24'h000000);
        check("async_reset_sec", {23'd0, sec_tick}, 24'd0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Load 23:59:58 and roll over midnight
        pulse_load(24'h173B3A);
        check("load_2359", data_ch, 24'h173B3A);
        for (int i = 0; i < 4; i++) step();
        check("adv_2359", data_ch, 24'h173B3B);
        for (int i = 0; i < 4; i++) step();
        check("rollover_data", data_ch, 24'h000000);
        check("rollover_day", {23'd0, day_tick}, 24'd1);
        step();

        // Range-checked loads
        pulse_load(24'h183C3D);
        check("load_illegal", data_ch, 24'h000000);
        check("load_illegal_day", {23'd0, day_tick}, 24'd0);
        step();
        pulse_load(24'h0C3C05);
        check("load_min_fix", data_ch, 24'h0C0005);
        step();

        // Held load request: only the first high cycle loads
        setup_imp = 1'b1;
        for (int i = 0; i < 20; i++) begin
            setup_data = {8'($urandom_range(0, 23)), 8'($urandom_range(0, 59)), 8'($urandom_range(0, 59))};
            step();
        end
        setup_imp = 1'b0;
        step();
        pulse_load(24'h010203);
        check("reload", data_ch, 24'h010203);
        step();

        // Load on the wrap cycle: load wins, no tick
        for (int k = 0; k < CLK_HZ && m_phase != CLK_HZ - 1; k++) step();
        pulse_load(24'h050505);
        check("wrap_load_data", data_ch, 24'h050505);
        check("wrap_load_tick", {23'd0, sec_tick}, 24'd0);
        for (int i = 0; i < 4; i++) step();
        check("wrap_next_adv", data_ch, 24'h050506);

        // Freeze at phase 2, then resume
        for (int k = 0; k < CLK_HZ && m_phase != 2; k++) step();
        run = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("frozen_data", data_ch, 24'h050506);
        run = 1'b1;
        for (int i = 0; i < 2; i++) step();
        check("resume_adv", data_ch, 24'h050507);
        run = 1'b0;
        step();
        pulse_load(24'h0A0B0C);
        check("load_while_stopped", data_ch, 24'h0A0B0C);
        for (int i = 0; i < 3; i++) step();
        run = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Randomized run/load/data
        for (int i = 0; i < 300; i++) begin
            run       = ($urandom_range(0, 9) != 0);
            setup_imp = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 1) == 0)
                setup_data = {8'($urandom_range(0, 23)), 8'($urandom_range(0, 59)), 8'($urandom_range(0, 59))};
            else if ($urandom_range(0, 3) == 0)
                setup_data = 24'h173B3B;
            else
                setup_data = 24'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
